// File: rtl/csr_pkg.sv
// CSR address map and operation encoding shared by the
// CSR file, the decoder and the forwarding unit.
package csr_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;

  typedef enum logic [1:0] {
    ILL = 2'b00,
    RW  = 2'b01,
    RS  = 2'b10,
    RC  = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves, each
// independently writable; a written half ignores increment/carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  logic [31:0] lo;
  logic [31:0] hi;
  logic        carry;

  // a write to lo replaces the wrapping increment, so no carry
  assign carry = inc & (&lo) & ~wr_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if (wr_lo)
        lo <= wdata;
      else if (inc)
        lo <= lo + 32'd1;
      if (wr_hi)
        hi <= wdata;
      else if (carry)
        hi <= hi + 32'd1;
    end
  end

  assign q = {hi, lo};

endmodule

// File: rtl/csr_file.sv
// Zicsr/Zicntr register file: address decode, RS/RC merge,
// illegal-access detection, read mux, mscratch and counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_en,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  input  logic             rs1_zero,
  input  logic             stall,
  input  logic             inst_retire,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             csr_illegal,
  output logic [CNT_W-1:0] csr_cycle,
  output logic [CNT_W-1:0] csr_instret
);

  csr_op_e         op;
  logic            sel_cyc_lo;
  logic            sel_cyc_hi;
  logic            sel_ins_lo;
  logic            sel_ins_hi;
  logic            sel_mcyc_lo;
  logic            sel_mcyc_hi;
  logic            sel_mins_lo;
  logic            sel_mins_hi;
  logic            sel_msc;
  logic            mapped;
  logic            ro;
  logic            wr_req;
  logic            we;
  logic [XLEN-1:0] old;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] mscratch;

  assign op = csr_op_e'(csr_op);

  assign sel_cyc_lo  = csr_addr == CSR_CYCLE;
  assign sel_cyc_hi  = csr_addr == CSR_CYCLEH;
  assign sel_ins_lo  = csr_addr == CSR_INSTRET;
  assign sel_ins_hi  = csr_addr == CSR_INSTRETH;
  assign sel_mcyc_lo = csr_addr == CSR_MCYCLE;
  assign sel_mcyc_hi = csr_addr == CSR_MCYCLEH;
  assign sel_mins_lo = csr_addr == CSR_MINSTRET;
  assign sel_mins_hi = csr_addr == CSR_MINSTRETH;
  assign sel_msc     = csr_addr == CSR_MSCRATCH;

  always_comb begin
    old    = '0;
    mapped = 1'b0;
    unique case (1'b1)
      sel_cyc_lo, sel_mcyc_lo: begin
        old    = csr_cycle[31:0];
        mapped = 1'b1;
      end
      sel_cyc_hi, sel_mcyc_hi: begin
        old    = csr_cycle[63:32];
        mapped = 1'b1;
      end
      sel_ins_lo, sel_mins_lo: begin
        old    = csr_instret[31:0];
        mapped = 1'b1;
      end
      sel_ins_hi, sel_mins_hi: begin
        old    = csr_instret[63:32];
        mapped = 1'b1;
      end
      sel_msc: begin
        old    = mscratch;
        mapped = 1'b1;
      end
      default: ;
    endcase
  end

  assign ro     = csr_addr[11:10] == 2'b11;
  assign wr_req = csr_en & ((op == RW) | ~rs1_zero);

  assign csr_illegal = csr_en &
    (~mapped | (op == ILL) | (wr_req & ro));

  assign we = wr_req & ~stall & ~csr_illegal;

  always_comb begin
    wval = csr_wdata;
    unique case (op)
      RW:      wval = csr_wdata;
      RS:      wval = old | csr_wdata;
      RC:      wval = old & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  assign csr_rdata = csr_en ? old : '0;

  always_ff @(posedge clk) begin
    if (rst)
      mscratch <= '0;
    else if (we & sel_msc)
      mscratch <= wval;
  end

  csr_counter64 u_cycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (we & sel_mcyc_lo),
    .wr_hi (we & sel_mcyc_hi),
    .wdata (wval),
    .q     (csr_cycle)
  );

  csr_counter64 u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire),
    .wr_lo (we & sel_mins_lo),
    .wr_hi (we & sel_mins_hi),
    .wdata (wval),
    .q     (csr_instret)
  );

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: vector table plus
// hand-written counter/reset sequences, checked via a queue.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rs1_zero;
  logic        stall;
  logic        inst_retire;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [63:0] csr_cycle;
  logic [63:0] csr_instret;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rz;
    logic        st;
    logic        cr;
    logic        use_cyc;
    logic [31:0] rd;
    logic        ill;
  } vec_t;

  typedef struct {
    logic        cr;
    logic [31:0] rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  csr_file dut (
    .clk         (clk),
    .rst         (rst),
    .csr_en      (csr_en),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .rs1_zero    (rs1_zero),
    .stall       (stall),
    .inst_retire (inst_retire),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .csr_cycle   (csr_cycle),
    .csr_instret (csr_instret)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, no summary reached");
    $fatal(1);
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic en, logic [1:0] op,
                       logic [11:0] addr, logic [31:0] wd,
                       logic rz, logic st, logic cr,
                       logic [31:0] rd, logic ill);
    exp_t e;
    csr_en    = en;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    rs1_zero  = rz;
    stall     = st;
    e.cr  = cr;
    e.rd  = rd;
    e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic sample(string nm);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_ill"}, {63'd0, csr_illegal}, {63'd0, e.ill});
      if (e.cr)
        chk({nm, "_rdata"}, {32'd0, csr_rdata}, {32'd0, e.rd});
    end
  endtask

  task automatic idle();
    csr_en    = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h000;
    csr_wdata = 32'd0;
    rs1_zero  = 1'b0;
    stall     = 1'b0;
  endtask

  // counter writes: old value time-dependent, only illegal checked
  task automatic wr(string nm, logic [11:0] addr,
                    logic [31:0] wd);
    drive(1'b1, RW, addr, wd, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    sample(nm);
    tick();
    idle();
  endtask

  function automatic vec_t mk(logic en, logic [1:0] op,
    logic [11:0] addr, logic [31:0] wd, logic rz, logic st,
    logic cr, logic uc, logic [31:0] rd, logic ill);
    vec_t v;
    v.en = en; v.op = op; v.addr = addr; v.wdata = wd;
    v.rz = rz; v.st = st; v.cr = cr; v.use_cyc = uc;
    v.rd = rd; v.ill = ill;
    return v;
  endfunction

  initial begin
    logic [7:0] pat;
    tbl[0]  = mk(1, RW,  12'h340, 32'hF0, 0, 0, 1, 0, 32'h00, 0);
    tbl[1]  = mk(1, RS,  12'h340, 32'h0F, 0, 0, 1, 0, 32'hF0, 0);
    tbl[2]  = mk(1, RC,  12'h340, 32'h30, 0, 0, 1, 0, 32'hFF, 0);
    tbl[3]  = mk(1, RS,  12'h340, 32'h00, 1, 0, 1, 0, 32'hCF, 0);
    tbl[4]  = mk(1, RW,  12'h340, 32'h55, 0, 1, 1, 0, 32'hCF, 0);
    tbl[5]  = mk(1, RS,  12'h340, 32'h00, 1, 0, 1, 0, 32'hCF, 0);
    tbl[6]  = mk(1, RW,  12'hC00, 32'h1234, 0, 0, 1, 1, 0, 1);
    tbl[7]  = mk(1, RS,  12'hC00, 32'h00, 1, 0, 1, 1, 0, 0);
    tbl[8]  = mk(1, RC,  12'hC80, 32'h01, 0, 0, 1, 0, 32'h0, 1);
    tbl[9]  = mk(1, RW,  12'h7C0, 32'hAA, 0, 0, 1, 0, 32'h0, 1);
    tbl[10] = mk(1, ILL, 12'h340, 32'h00, 1, 0, 0, 0, 32'h0, 1);
    tbl[11] = mk(0, RW,  12'h340, 32'h99, 0, 0, 1, 0, 32'h0, 0);
    tbl[12] = mk(1, RS,  12'h340, 32'h00, 1, 0, 1, 0, 32'hCF, 0);
    tbl[13] = mk(1, RC,  12'h340, 32'hFF, 0, 1, 1, 0, 32'hCF, 0);
    tbl[14] = mk(1, RS,  12'h340, 32'h00, 1, 0, 1, 0, 32'hCF, 0);
    tbl[15] = mk(1, RS,  12'hB00, 32'h00, 1, 1, 1, 1, 0, 0);
    tbl[16] = mk(1, RS,  12'h340, 32'hFF, 1, 0, 1, 0, 32'hCF, 0);

    rst = 1'b1;
    inst_retire = 1'b0;
    idle();
    tick();
    rst = 1'b0;
    chk("rst_cycle", csr_cycle, 64'd0);
    chk("rst_instret", csr_instret, 64'd0);
    drive(0, RW, 12'h340, 32'h0, 0, 0, 1, 32'h0, 0);
    sample("idle_out");

    for (int i = 0; i < 10; i++)
      tick();
    chk("cycle10", csr_cycle, 64'd10);
    drive(1, RS, CSR_CYCLE, 32'h0, 1, 0, 1, 32'h0000000A, 0);
    sample("rd_c00");
    tick();
    idle();

    pat = 8'b1011_0101;
    for (int i = 0; i < 8; i++) begin
      inst_retire = pat[i];
      tick();
    end
    inst_retire = 1'b0;
    chk("instret5", csr_instret, 64'd5);
    inst_retire = 1'b1;
    drive(1, RW, CSR_MINSTRET, 32'h100, 0, 0, 1, 32'd5, 0);
    sample("wr_b02");
    tick();
    inst_retire = 1'b0;
    idle();
    chk("instret_wr_wins", csr_instret, 64'h100);

    wr("wr_b80_0", CSR_MCYCLEH, 32'h0);
    wr("wr_b00_ff", CSR_MCYCLE, 32'hFFFF_FFFF);
    chk("cyc_lo_ff", csr_cycle, 64'h0000_0000_FFFF_FFFF);
    tick();
    chk("cyc_carry", csr_cycle, 64'h0000_0001_0000_0000);
    drive(1, RS, CSR_CYCLE, 32'h0, 1, 0, 1, 32'h0, 0);
    sample("rd_c00_0");
    tick();
    drive(1, RS, CSR_CYCLEH, 32'h0, 1, 0, 1, 32'h1, 0);
    sample("rd_c80_1");
    tick();
    idle();

    wr("wr_b00_ff2", CSR_MCYCLE, 32'hFFFF_FFFF);
    wr("wr_b80_7", CSR_MCYCLEH, 32'h7);
    chk("hi_wr_drops_carry", csr_cycle, 64'h0000_0007_0000_0000);
    wr("wr_b00_ff3", CSR_MCYCLE, 32'hFFFF_FFFF);
    wr("wr_b00_5", CSR_MCYCLE, 32'h5);
    chk("lo_wr_no_carry", csr_cycle, 64'h0000_0007_0000_0005);
    wr("wr_b80_ff", CSR_MCYCLEH, 32'hFFFF_FFFF);
    wr("wr_b00_ff4", CSR_MCYCLE, 32'hFFFF_FFFF);
    chk("cyc_all_ones", csr_cycle, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("cyc_wrap", csr_cycle, 64'd0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].en, tbl[i].op, tbl[i].addr, tbl[i].wdata,
            tbl[i].rz, tbl[i].st, tbl[i].cr,
            tbl[i].use_cyc ? 32'(i) : tbl[i].rd, tbl[i].ill);
      sample($sformatf("vec%0d", i));
      tick();
    end
    idle();
    chk("cyc_after_tbl", csr_cycle, 64'd17);
    chk("instret_steady", csr_instret, 64'h100);

    rst = 1'b1;
    inst_retire = 1'b1;
    csr_en    = 1'b1;
    csr_op    = RW;
    csr_addr  = CSR_MSCRATCH;
    csr_wdata = 32'h77;
    tick();
    rst = 1'b0;
    inst_retire = 1'b0;
    idle();
    chk("rst_mid_cycle", csr_cycle, 64'd0);
    chk("rst_mid_instret", csr_instret, 64'd0);
    drive(1, RS, CSR_MSCRATCH, 32'h0, 1, 0, 1, 32'h0, 0);
    sample("rst_mid_msc");
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
